// File: rtl/legv8_mem_pkg.sv
// Shared encodings for the LEGv8 memory responder: access sizes, FSM states
// and the bytes-per-size helper.
package legv8_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    logic [3:0] n;
    case (sz)
      SZ_BYTE: n = 4'd1;
      SZ_HALF: n = 4'd2;
      SZ_WORD: n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_resp_lane_align.sv
// Byte-lane alignment for 64-bit storage words: extracts addressed lanes
// (right-justified, zero-extended) and merges new lanes into a word.
module mem_resp_lane_align
  import legv8_mem_pkg::*;
(
  input  logic [63:0] i_word,
  input  logic [63:0] i_wdata,
  input  logic [2:0]  i_offset,
  input  logic [1:0]  i_size,
  output logic [63:0] o_rdata,
  output logic [63:0] o_merged
);

  logic [63:0] w_mask;
  logic [5:0]  w_shamt;

  always_comb begin
    w_mask = '1;
    case (i_size)
      SZ_BYTE: w_mask = 64'h0000_0000_0000_00FF;
      SZ_HALF: w_mask = 64'h0000_0000_0000_FFFF;
      SZ_WORD: w_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_mask = '1;
    endcase
  end

  assign w_shamt  = {i_offset, 3'b000};
  assign o_rdata  = (i_word >> w_shamt) & w_mask;
  assign o_merged = (i_word & ~(w_mask << w_shamt)) | ((i_wdata & w_mask) << w_shamt);

endmodule

// File: rtl/legv8_mem_responder.sv
// Memory-side responder on the LEGv8 shared tri-state bus with programmable
// wait states. Optional access counter: define MEM_RESP_ACCESS_CNT_EN.
module legv8_mem_responder
  import legv8_mem_pkg::*;
#(
  parameter int          ADDR_BITS   = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  inout  wire  [63:0] data,
  output logic        ready,
`ifdef MEM_RESP_ACCESS_CNT_EN
  output logic        error,
  output logic [15:0] access_count
`else
  output logic        error
`endif
);

  state_e r_state, w_next;

  logic [3:0]           r_cnt;
  logic                 r_op_wr;
  logic [ADDR_BITS-1:0] r_idx;
  logic [2:0]           r_off;
  logic [1:0]           r_size;
  logic                 r_misal;
  logic [63:0]          r_wdata;
  logic [63:0]          r_rd_data;
  logic                 r_drive;
  logic                 r_ready;
  logic                 r_error;
  logic [63:0]          r_mem [2**ADDR_BITS];

  logic                 w_hit, w_accept, w_both_err, w_req_held, w_enter_done;
  logic [3:0]           w_bytes;
  logic                 w_misal_in;
  logic                 w_idle;
  logic                 w_cur_wr, w_cur_misal;
  logic [ADDR_BITS-1:0] w_cur_idx;
  logic [2:0]           w_cur_off;
  logic [1:0]           w_cur_size;
  logic [63:0]          w_cur_wdata;
  logic [63:0]          w_lane_rd, w_merged;

  assign w_hit      = address[31:ADDR_BITS+3] == BASE_ADDR[31:ADDR_BITS+3];
  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_idle && (mem_read ^ mem_write) && w_hit;
  assign w_both_err = w_idle && mem_read && mem_write && w_hit;
  assign w_req_held = r_op_wr ? mem_write : mem_read;
  assign w_bytes    = size_bytes(size);
  assign w_misal_in = ({1'b0, address[2:0]} & (w_bytes - 4'd1)) != 4'd0;

  // With zero wait states DONE is entered on the accepting edge, so the
  // commit path must see the live request rather than the latched copy.
  assign w_cur_wr    = w_idle ? mem_write            : r_op_wr;
  assign w_cur_idx   = w_idle ? address[ADDR_BITS+2:3] : r_idx;
  assign w_cur_off   = w_idle ? address[2:0]         : r_off;
  assign w_cur_size  = w_idle ? size                 : r_size;
  assign w_cur_misal = w_idle ? w_misal_in           : r_misal;
  assign w_cur_wdata = w_idle ? data                 : r_wdata;

  mem_resp_lane_align u_align (
    .i_word   (r_mem[w_cur_idx]),
    .i_wdata  (w_cur_wdata),
    .i_offset (w_cur_off),
    .i_size   (w_cur_size),
    .o_rdata  (w_lane_rd),
    .o_merged (w_merged)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (r_cnt <= 4'd1) w_next = ST_DONE;
      ST_DONE: if (!w_req_held) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_done = (w_next == ST_DONE) && (r_state != ST_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_op_wr   <= 1'b0;
      r_idx     <= '0;
      r_off     <= '0;
      r_size    <= '0;
      r_misal   <= 1'b0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_drive   <= 1'b0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(WAIT_STATES);
        r_op_wr <= mem_write;
        r_idx   <= address[ADDR_BITS+2:3];
        r_off   <= address[2:0];
        r_size  <= size;
        r_misal <= w_misal_in;
        r_wdata <= data;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_done && !w_cur_wr)
        r_rd_data <= w_cur_misal ? '0 : w_lane_rd;
      r_ready <= (w_next == ST_DONE);
      r_drive <= (w_next == ST_DONE) && !w_cur_wr;
      if (w_both_err || (w_enter_done && w_cur_misal))
        r_error <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_enter_done && w_cur_wr && !w_cur_misal)
      r_mem[w_cur_idx] <= w_merged;
  end

`ifdef MEM_RESP_ACCESS_CNT_EN
  logic [15:0] r_access_count;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             r_access_count <= '0;
    else if (w_enter_done) r_access_count <= r_access_count + 16'd1;
  end
  assign access_count = r_access_count;
`endif

  assign data  = r_drive ? r_rd_data : 'z;
  assign ready = r_ready;
  assign error = r_error;

endmodule

// File: tb/tb_legv8_mem_responder.sv
// Directed-vector bench for legv8_mem_responder: one instance with one wait
// state and one with zero wait states.
module tb_legv8_mem_responder;
  import legv8_mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [1:0]  size = '0;
  logic [63:0] tb_wdata = '0;
  logic        tb_oe1 = 1'b0, tb_oe0 = 1'b0;
  logic        rd1 = 1'b0, wr1 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
  logic        ready1, error1, ready0, error0;
  wire  [63:0] data1, data0;
`ifdef MEM_RESP_ACCESS_CNT_EN
  logic [15:0] count1, count0;
`endif

  assign data1 = tb_oe1 ? tb_wdata : 'z;
  assign data0 = tb_oe0 ? tb_wdata : 'z;

  always #5 clock = ~clock;

  legv8_mem_responder #(.ADDR_BITS(6), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut1 (
    .clock(clock), .reset(reset), .address(address), .mem_read(rd1),
    .mem_write(wr1), .size(size), .data(data1), .ready(ready1),
`ifdef MEM_RESP_ACCESS_CNT_EN
    .error(error1), .access_count(count1)
`else
    .error(error1)
`endif
  );

  legv8_mem_responder #(.ADDR_BITS(6), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .address(address), .mem_read(rd0),
    .mem_write(wr0), .size(size), .data(data0), .ready(ready0),
`ifdef MEM_RESP_ACCESS_CNT_EN
    .error(error0), .access_count(count0)
`else
    .error(error0)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one request; lat = edges until ready (0 if ready never came).
  task automatic run(input bit sel0, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [1:0] sz, input logic [63:0] wd,
                     output int lat, output logic [63:0] rdat);
    address = a; size = sz; tb_wdata = wd;
    if (sel0) begin rd0 = rd; wr0 = wr; tb_oe0 = wr; end
    else      begin rd1 = rd; wr1 = wr; tb_oe1 = wr; end
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clock); #1;
      if (sel0 ? ready0 : ready1) begin lat = i; break; end
    end
    rdat = sel0 ? data0 : data1;
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; tb_oe0 = 1'b0; tb_oe1 = 1'b0;
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic [63:0] wd;
    int          lat;
    logic [63:0] rdat;
    logic        err;
  } vec_t;

  vec_t v[15];
  int          lat;
  logic [63:0] rdat;

  initial begin
    v[0]  = '{0, 1, 32'h008, SZ_DOUBLE, 64'h0123_4567_89AB_CDEF, 2, 64'h0, 0};
    v[1]  = '{1, 0, 32'h008, SZ_DOUBLE, 64'h0, 2, 64'h0123_4567_89AB_CDEF, 0};
    v[2]  = '{0, 1, 32'h00A, SZ_BYTE,   64'hFFFF_FFFF_FFFF_FF5A, 2, 64'h0, 0};
    v[3]  = '{1, 0, 32'h008, SZ_DOUBLE, 64'h0, 2, 64'h0123_4567_895A_CDEF, 0};
    v[4]  = '{1, 0, 32'h00A, SZ_HALF,   64'h0, 2, 64'h0000_0000_0000_895A, 0};
    v[5]  = '{1, 0, 32'h00C, SZ_WORD,   64'h0, 2, 64'h0000_0000_0123_4567, 0};
    v[6]  = '{1, 0, 32'h00F, SZ_BYTE,   64'h0, 2, 64'h0000_0000_0000_0001, 0};
    v[7]  = '{1, 0, 32'h00E, SZ_HALF,   64'h0, 2, 64'h0000_0000_0000_0123, 0};
    v[8]  = '{0, 1, 32'h009, SZ_HALF,   64'h0000_0000_0000_FFFF, 2, 64'h0, 1};
    v[9]  = '{1, 0, 32'h008, SZ_DOUBLE, 64'h0, 2, 64'h0123_4567_895A_CDEF, 1};
    v[10] = '{1, 1, 32'h008, SZ_DOUBLE, 64'h0, 0, 64'h0, 1};
    v[11] = '{1, 0, 32'h1000, SZ_DOUBLE, 64'h0, 0, 64'h0, 1};
    v[12] = '{1, 0, 32'h00A, SZ_WORD,   64'h0, 2, 64'h0, 1};
    v[13] = '{0, 1, 32'h1F8, SZ_DOUBLE, 64'hFEED_FACE_CAFE_BEEF, 2, 64'h0, 1};
    v[14] = '{1, 0, 32'h1F8, SZ_DOUBLE, 64'h0, 2, 64'hFEED_FACE_CAFE_BEEF, 1};

    repeat (2) @(posedge clock);
    #1;
    chk("reset_ready", 64'(ready1), 64'h0);
    chk("reset_error", 64'(error1), 64'h0);
    chk("reset_bus",   64'(dut1.r_drive), 64'h0);
`ifdef MEM_RESP_ACCESS_CNT_EN
    chk("reset_count", 64'(count1), 64'h0);
`endif
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 15; i++) begin
      chk($sformatf("v%0d_bus_before", i), 64'(dut1.r_drive), 64'h0);
      run(1'b0, v[i].rd, v[i].wr, v[i].addr, v[i].sz, v[i].wd, lat, rdat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v[i].lat));
      if (v[i].rd && !v[i].wr && v[i].lat != 0)
        chk($sformatf("v%0d_rdata", i), rdat, v[i].rdat);
      chk($sformatf("v%0d_error", i), 64'(error1), 64'(v[i].err));
      chk($sformatf("v%0d_ready_after", i), 64'(ready1), 64'h0);
      chk($sformatf("v%0d_bus_after", i), 64'(dut1.r_drive), 64'h0);
    end

    // Reset during WAIT of a write: the write is lost.
    run(1'b0, 1'b0, 1'b1, 32'h010, SZ_DOUBLE, 64'hA5A5_0000_1111_2222, lat, rdat);
    chk("pre_write_latency", 64'(lat), 64'd2);
    address = 32'h010; size = SZ_DOUBLE; tb_wdata = 64'h9999_8888_7777_6666;
    tb_oe1 = 1'b1; wr1 = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1; #1;
    chk("rst_wait_ready", 64'(ready1), 64'h0);
    chk("rst_wait_bus",   64'(dut1.r_drive), 64'h0);
    chk("rst_wait_error", 64'(error1), 64'h0);
    wr1 = 1'b0; tb_oe1 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    run(1'b0, 1'b1, 1'b0, 32'h010, SZ_DOUBLE, 64'h0, lat, rdat);
    chk("post_rst_latency", 64'(lat), 64'd2);
    chk("post_rst_rdata", rdat, 64'hA5A5_0000_1111_2222);

    // Held read stays in DONE; reset then releases the bus immediately.
    address = 32'h00C; size = SZ_WORD; rd1 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("hold_ready0", 64'(ready1), 64'h1);
    repeat (2) @(posedge clock);
    #1;
    chk("hold_ready1", 64'(ready1), 64'h1);
    chk("hold_rdata", data1, 64'h0000_0000_0123_4567);
    #2 reset = 1'b1; #1;
    chk("rst_done_ready", 64'(ready1), 64'h0);
    chk("rst_done_bus",   64'(dut1.r_drive), 64'h0);
    rd1 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Zero wait states: three reads with a one-cycle gap each.
    for (int i = 0; i < 3; i++) begin
      run(1'b1, 1'b1, 1'b0, 32'(i * 8), SZ_DOUBLE, 64'h0, lat, rdat);
      chk($sformatf("ws0_read%0d_latency", i), 64'(lat), 64'd1);
    end
`ifdef MEM_RESP_ACCESS_CNT_EN
    chk("ws0_access_count", 64'(count0), 64'd3);
`endif
    run(1'b1, 1'b0, 1'b1, 32'h018, SZ_DOUBLE, 64'hDEAD_BEEF_0BAD_F00D, lat, rdat);
    chk("ws0_write_latency", 64'(lat), 64'd1);
    run(1'b1, 1'b1, 1'b0, 32'h01C, SZ_WORD, 64'h0, lat, rdat);
    chk("ws0_read_latency", 64'(lat), 64'd1);
    chk("ws0_rdata", rdat, 64'h0000_0000_DEAD_BEEF);
    chk("ws0_bus_after", 64'(dut0.r_drive), 64'h0);
    chk("ws0_error", 64'(error0), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
